seq_chunk_adder: RTL and testbench
==================================

# seq_chunk_adder

Parametrised multi-cycle adder that replaces the fixed 4-bit ripple-carry adder where wide operands are needed and a full-width carry chain is too slow. Operands are captured on a start pulse and added CHUNK bits per clock, least-significant chunk first. A registered carry links each chunk to the next. The result is presented with a one-cycle done pulse and held until the next operation completes. It sits between operand registers and any consumer that tolerates a WIDTH/CHUNK-cycle latency.

## Interface
- WIDTH, 16, operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle; 1 ≤ CHUNK ≤ WIDTH.
- Derived: NCH = WIDTH/CHUNK, the number of chunk cycles. The index counter is $clog2(NCH)+1 bits.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new addition; sampled only in IDLE.
- a  in  WIDTH  operand A, captured when start is accepted.
- b  in  WIDTH  operand B, captured when start is accepted.
- cin  in  1  carry-in, captured when start is accepted.
- busy  out  1  high while chunks are being processed (state RUN).
- done  out  1  one-cycle pulse; sum/cout/ovf are valid from this cycle onward.
- sum  out  WIDTH  registered result.
- cout  out  1  registered carry-out of the MSB.
- ovf  out  1  signed overflow flag; present only with SCA_OVF_EN.

## Operation
- FSM has three states: IDLE, RUN and DONE.
- IDLE, with start=1:
  - latch a and b into the operand registers; carry ← cin; idx ← 0.
  - go to RUN.
- IDLE, with start=0: stay in IDLE.
- RUN, each cycle:
  - {c, s} = a_r[idx*CHUNK +: CHUNK] + b_r[idx*CHUNK +: CHUNK] + carry, computed at CHUNK+1 bits.
  - the work register slice idx ← s; carry ← c; idx ← idx+1.
- RUN, on the cycle idx = NCH-1:
  - sum ← the completed work value, including this cycle's slice; cout ← c.
  - ovf ← carry into bit WIDTH-1 XOR c, when enabled.
  - go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE unconditionally.
- start outside IDLE (in RUN or DONE) is ignored and not queued. Operands changing during RUN have no effect.
- Throughput is one operation per NCH+2 cycles. Holding start high continuously restarts in the cycle after DONE.
- sum, cout and ovf change only at the edge that enters DONE. Between operations they hold the last result.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the true bit WIDTH. The ovf flag treats a and b as two's complement.

## Timing
- Reset (rst=1 at an edge) from any state:
  - state IDLE, idx 0, carry 0, busy 0, done 0, sum 0, cout 0, ovf 0.
  - reset overrides start in the same cycle.
- Reset during RUN aborts the operation: no done pulse, and the partial result is discarded.
- Let edge E be the edge where start is accepted:
  - busy=1 from E to E+NCH, i.e. NCH cycles.
  - results update at E+NCH; done=1 in the cycle between E+NCH and E+NCH+1.
- Latency is NCH cycles from start acceptance to done.
- CHUNK=WIDTH (NCH=1): RUN lasts one cycle, and done follows one cycle after the start edge.
- busy and done are never high together.

## Configuration
- SCA_OVF_EN defined:
  - the ovf port and its register exist.
  - ovf = (carry into MSB) XOR (carry out of MSB) for the last operation; it updates with sum and resets to 0.
- SCA_OVF_EN undefined:
  - no ovf port and no extra logic.
  - all other behaviour is identical.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 (NCH=4), with SCA_OVF_EN defined.
- Hold rst for 2 cycles → busy=0, done=0, sum=16'h0000, cout=0, ovf=0; start while rst=1 is ignored.
- a=16'h0001, b=16'h0000, cin=1, pulse start → busy high for 4 cycles, then done pulse with sum=16'h0002, cout=0, ovf=0.
- a=16'hFFFF, b=16'h0001, cin=0 → carry ripples through all chunks; sum=16'h0000, cout=1, ovf=0. Then a=16'h7FFF, b=16'h0001 → sum=16'h8000, cout=0, ovf=1.
- Start a=16'h1234, b=16'h4321, cin=0; during RUN drive start=1 with a=16'hFFFF, b=16'hFFFF → second request ignored; a single done with sum=16'h5555; sum is unchanged before done.
- Start an operation, then assert rst in the 2nd RUN cycle → no done pulse, sum=0. Then a=16'hC00C, b=16'hC00C, cin=1 → sum=16'h8019, cout=1, ovf=0.
- Rebuild with CHUNK=16 (NCH=1): a=16'h00FF, b=16'h0001 → busy high for 1 cycle, done one cycle after the start edge, sum=16'h0100.

Source files
------------

// File: rtl/seq_chunk_adder_if.sv
// Handshake and data bundle for seq_chunk_adder.
// The ovf signal exists only when SCA_OVF_EN is defined.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SCA_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: CHUNK bits per clock, LSB chunk first.
// Optional signed-overflow flag enabled by SCA_OVF_EN.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic              clk,
    input logic              rst,
    seq_chunk_adder_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = $clog2(NCH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_nx;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] as;
    logic [CHUNK-1:0] bs;
    logic [CHUNK:0]   t;
    logic             last;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Chunk mux and slice write-back, one chunk per RUN cycle
    always_comb begin
        as      = '0;
        bs      = '0;
        work_nx = work;
        for (int i = 0; i < NCH; i++) begin
            if (idx == IW'(i)) begin
                as = a_r[i*CHUNK +: CHUNK];
                bs = b_r[i*CHUNK +: CHUNK];
            end
        end
        t = {1'b0, as} + {1'b0, bs} + {{CHUNK{1'b0}}, carry};
        for (int i = 0; i < NCH; i++) begin
            if (idx == IW'(i)) work_nx[i*CHUNK +: CHUNK] = t[CHUNK-1:0];
        end
        last = (idx == IW'(NCH - 1));
    end

`ifdef SCA_OVF_EN
    logic ovf_r;
    logic cmsb;

    // Carry into the MSB recovered from its sum bit
    assign cmsb = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ t[CHUNK-1];

    always_ff @(posedge clk) begin
        if (rst)
            ovf_r <= 1'b0;
        else if (state == RUN && last)
            ovf_r <= cmsb ^ t[CHUNK];
    end

    assign bus.ovf = ovf_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            work   <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            carry  <= 1'b0;
            idx    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r   <= bus.a;
                        b_r   <= bus.b;
                        carry <= bus.cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    work  <= work_nx;
                    carry <= t[CHUNK];
                    idx   <= idx + IW'(1);
                    if (last) begin
                        sum_r  <= work_nx;
                        cout_r <= t[CHUNK];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Testbench for seq_chunk_adder: cycle model plus directed checks.
// Covers WIDTH=16 with CHUNK=4 and CHUNK=16.
module tb_seq_chunk_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nerr = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_chunk_adder_if #(.WIDTH(16)) bx ();
    seq_chunk_adder_if #(.WIDTH(16)) by ();

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bx)
    );
    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .bus(by)
    );

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: plain-arithmetic result, NCH=4 busy cycles, then done
    logic [16:0] m_full;
    logic        m_ovf;
    logic [16:0] pend;
    logic        pend_ovf;
    int          ph;
    int          cnt;
    logic [15:0] esum;
    logic        ecout;
    logic        eovf;

    assign m_full = {1'b0, bx.a} + {1'b0, bx.b} + {16'd0, bx.cin};
    assign m_ovf  = (bx.a[15] == bx.b[15]) && (m_full[15] != bx.a[15]);

    always @(posedge clk) begin
        if (rst) begin
            ph    <= 0;
            cnt   <= 0;
            esum  <= '0;
            ecout <= 1'b0;
            eovf  <= 1'b0;
        end else begin
            case (ph)
                0: if (bx.start) begin
                    pend     <= m_full;
                    pend_ovf <= m_ovf;
                    cnt      <= 3;
                    ph       <= 1;
                end
                1: if (cnt == 0) begin
                    esum  <= pend[15:0];
                    ecout <= pend[16];
                    eovf  <= pend_ovf;
                    ph    <= 2;
                end else begin
                    cnt <= cnt - 1;
                end
                default: ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(bx.busy), 32'(ph == 1));
            check("done", 32'(bx.done), 32'(ph == 2));
            check("sum", 32'(bx.sum), 32'(esum));
            check("cout", 32'(bx.cout), 32'(ecout));
            check("busy_done_excl", 32'(bx.busy & bx.done), 32'd0);
`ifdef SCA_OVF_EN
            check("ovf", 32'(bx.ovf), 32'(eovf));
`endif
        end
    end

    task automatic go(input logic [15:0] a, input logic [15:0] b,
                      input logic c);
        @(posedge clk); #1;
        bx.start = 1'b1; bx.a = a; bx.b = b; bx.cin = c;
        @(posedge clk); #1;
        bx.start = 1'b0;
    endtask

    // Waits for done on the CHUNK=4 instance; returns busy cycles seen
    task automatic wait_done(input string nm, output int nb);
        bit seen = 1'b0;
        nb = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bx.busy) nb++;
            if (bx.done) seen = 1'b1;
        end
        check({nm, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic lit(input string nm, input logic [15:0] s,
                       input logic co, input logic ov);
        check({nm, "_sum"}, 32'(bx.sum), 32'(s));
        check({nm, "_cout"}, 32'(bx.cout), 32'(co));
`ifdef SCA_OVF_EN
        check({nm, "_ovf"}, 32'(bx.ovf), 32'(ov));
`else
        if (ov === 1'bx) nchk++;
`endif
    endtask

    initial begin
        int nb;
        int nd;
        bx.start = 1'b1; bx.a = 16'hFFFF; bx.b = 16'hFFFF; bx.cin = 1'b1;
        by.start = 1'b0; by.a = '0; by.b = '0; by.cin = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        bx.start = 1'b0;
        check("rst_busy", 32'(bx.busy), 32'd0);
        check("rst_done", 32'(bx.done), 32'd0);
        lit("rst", 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;

        go(16'h0001, 16'h0000, 1'b1);
        wait_done("t1", nb);
        check("t1_busy_cycles", 32'(nb), 32'd4);
        lit("t1", 16'h0002, 1'b0, 1'b0);

        go(16'hFFFF, 16'h0001, 1'b0);
        wait_done("t2", nb);
        lit("t2", 16'h0000, 1'b1, 1'b0);

        go(16'h7FFF, 16'h0001, 1'b0);
        wait_done("t3", nb);
        lit("t3", 16'h8000, 1'b0, 1'b1);

        go(16'h1234, 16'h4321, 1'b0);
        bx.start = 1'b1; bx.a = 16'hFFFF; bx.b = 16'hFFFF;
        @(negedge clk);
        check("t4_hold_sum", 32'(bx.sum), 32'h8000);
        @(posedge clk); #1;
        bx.start = 1'b0;
        wait_done("t4", nb);
        lit("t4", 16'h5555, 1'b0, 1'b0);
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bx.done || bx.busy) nd++;
        end
        check("t4_no_second_op", 32'(nd), 32'd0);

        go(16'hAAAA, 16'h5555, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bx.done) nd++;
        end
        check("t5_abort_no_done", 32'(nd), 32'd0);
        lit("t5_abort", 16'h0000, 1'b0, 1'b0);

        go(16'hC00C, 16'hC00C, 1'b1);
        wait_done("t6", nb);
        lit("t6", 16'h8019, 1'b1, 1'b0);

        @(posedge clk); #1;
        by.start = 1'b1; by.a = 16'h00FF; by.b = 16'h0001; by.cin = 1'b0;
        @(posedge clk); #1;
        by.start = 1'b0;
        check("n1_busy", 32'(by.busy), 32'd1);
        check("n1_done_early", 32'(by.done), 32'd0);
        @(posedge clk); #1;
        check("n1_done", 32'(by.done), 32'd1);
        check("n1_busy_off", 32'(by.busy), 32'd0);
        check("n1_sum", 32'(by.sum), 32'h0100);
        check("n1_cout", 32'(by.cout), 32'd0);
        @(posedge clk); #1;
        check("n1_done_pulse", 32'(by.done), 32'd0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
